bitblt_mul_arb: RTL and testbench
=================================

BITBLT_MUL_ARB -- requirements
Module: bitblt_mul_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of base and result address.
REQ-002 SHALL have parameter CNT_W, default 16: width of per-requester served counters.
REQ-003 SHALL have port ap_clk, input, 1: the single clock; all logic rising-edge.
REQ-004 SHALL have port ap_rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cfg_stride, input, 11: line stride in pixels; static while not IDLE.
REQ-006 SHALL have port cfg_base[0:1], input, 2xADDR_W: base addresses (0 = src, 1 = dst); static while not IDLE.
REQ-007 SHALL have ports req_valid[i]/req_ready[i], input/output, 1 each: request handshake per requester i in {0,1}.
REQ-008 SHALL have ports req_x[i]/req_y[i], input, 11 each: pixel coordinates.
REQ-009 SHALL have ports rsp_valid[i]/rsp_ready[i], output/input, 1 each: response handshake.
REQ-010 SHALL have port rsp_addr, output, ADDR_W: result, meaningful only for the requester whose rsp_valid is high.
REQ-011 SHALL have ports served_cnt[0:1], output, 2xCNT_W: completed-response counts.

Function
REQ-012 SHALL share one 11x11 unsigned multiplier (22-bit product) between both requesters; at most one transaction in flight.
REQ-013 SHALL implement the FSM IDLE -> MUL -> HOLD -> IDLE; MUL lasts 1 cycle (2 with BITBLT_MUL_PIPE_EN).
REQ-014 SHALL assert req_ready[i] combinationally only in IDLE and only for the granted requester; at most one req_ready high per cycle.
REQ-015 SHALL grant, in IDLE: the sole valid requester; if both valid, the requester not granted last (round-robin pointer, reset value favours 0).
REQ-016 SHALL register x, y, requester id and the selected base on acceptance; the pointer updates only on acceptance.
REQ-017 SHALL compute rsp_addr = base + zero_ext(y*cfg_stride) + zero_ext(x), wrapping modulo 2^ADDR_W.
REQ-018 SHALL assert rsp_valid[id] in HOLD, the first cycle after MUL: acceptance at edge N gives rsp_valid from N+1 (N+2 with the macro).
REQ-019 SHALL hold rsp_valid and rsp_addr stable until rsp_ready[id], then return to IDLE next cycle; sustained throughput is one per 3 cycles (4 with the macro).
REQ-020 SHALL ignore rsp_ready for the non-active requester and ignore req_valid outside IDLE.
REQ-021 SHALL increment served_cnt[id] on each response handshake, wrapping from 2^CNT_W-1 to 0.

Reset
REQ-022 SHALL, when ap_rst is sampled high (including mid-transaction), on that edge: state=IDLE, drop in-flight data, rsp_valid=0, rsp_addr=0, served_cnt=0, pointer=favour 0; req_ready stays 0 while ap_rst is high.

Configuration
REQ-023 SHALL, with BITBLT_MUL_PIPE_EN defined, register the multiplier product (MUL = 2 cycles); without it, the product feeds the adder in the same cycle (MUL = 1 cycle); the result is identical in both cases.

Structure
REQ-024 SHALL take the state enum, coordinate width (11), product width (22) and requester ids from the shared package bitblt_arb_pkg.
REQ-025 SHALL instantiate the multiplier as one sub-module, bitblt_arb_mul (combinational 11x11 unsigned).

Verification
REQ-026 Reset during MUL, both requesters valid -> FSM IDLE, no rsp_valid, req_ready[0] high on the first cycle after release.
REQ-027 Single req0 x=5 y=3 stride=640 base0=0x1000 -> rsp_valid[0] at N+1, rsp_addr=0x1785.
REQ-028 Both valid continuously, rsp_ready tied high -> grants alternate 0,1,0,1; served_cnt equal after 8 responses.
REQ-029 x=2047 y=2047 stride=2047 base=0xFFFFFFFF -> rsp_addr=0x003FF7FF (wrapped).
REQ-030 rsp_ready[0] held low 5 cycles -> rsp_addr stable, req_ready both low, no new grant until the handshake.
REQ-031 BITBLT_MUL_PIPE_EN build, same stimulus as REQ-027 -> identical address at N+2.

Source files
------------

// File: rtl/bitblt_arb_pkg.sv
// Shared definitions for the two-requester BitBLT address arbiter:
// FSM states, coordinate/product widths and requester ids.
package bitblt_arb_pkg;

  localparam int COORD_W = 11;
  localparam int PROD_W  = 22;

  localparam logic REQ_SRC = 1'b0;
  localparam logic REQ_DST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/bitblt_arb_mul.sv
// Combinational 11x11 unsigned multiplier shared by both requesters.
module bitblt_arb_mul
  import bitblt_arb_pkg::*;
(
  input  logic [COORD_W-1:0] a_i,
  input  logic [COORD_W-1:0] b_i,
  output logic [PROD_W-1:0]  p_o
);

  assign p_o = {{(PROD_W-COORD_W){1'b0}}, a_i} * {{(PROD_W-COORD_W){1'b0}}, b_i};

endmodule

// File: rtl/bitblt_mul_arb.sv
// Round-robin arbiter in front of one shared multiplier computing
// base + y*stride + x. Define BITBLT_MUL_PIPE_EN to register the product.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and rsp_valid/rsp_addr hold until
// the active requester's rsp_ready completes the transfer.
module bitblt_mul_arb
  import bitblt_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [10:0]            cfg_stride,
  input  logic [1:0][ADDR_W-1:0] cfg_base,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][10:0]       req_x,
  input  logic [1:0][10:0]       req_y,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [ADDR_W-1:0]      rsp_addr,
  output logic [1:0][CNT_W-1:0]  served_cnt,
  output logic [1:0]             dbg_state
);

  state_e               state_q, state_d;
  logic                 pri_q;
  logic                 id_q;
  logic [COORD_W-1:0]   x_q, y_q;
  logic [ADDR_W-1:0]    base_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [1:0][CNT_W-1:0] cnt_q;

  logic                 gnt;
  logic                 accept;
  logic                 rsp_hs;
  logic                 mul_done;
  logic [PROD_W-1:0]    prod;
  logic [PROD_W-1:0]    prod_use;
  logic [ADDR_W-1:0]    addr_sum;

  bitblt_arb_mul u_mul (
    .a_i (y_q),
    .b_i (cfg_stride),
    .p_o (prod)
  );

`ifdef BITBLT_MUL_PIPE_EN
  logic              ph_q;
  logic [PROD_W-1:0] prod_q;

  // First MUL cycle captures the product, second one feeds the adder.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ph_q   <= 1'b0;
      prod_q <= '0;
    end else begin
      ph_q <= (state_q == ST_MUL) && !ph_q;
      if ((state_q == ST_MUL) && !ph_q) prod_q <= prod;
    end
  end

  assign prod_use = prod_q;
  assign mul_done = ph_q;
`else
  assign prod_use = prod;
  assign mul_done = 1'b1;
`endif

  // With both valid the pointer picks; otherwise the sole valid one wins.
  assign gnt      = (req_valid == 2'b11) ? pri_q : req_valid[1];
  assign accept   = (state_q == ST_IDLE) && (|req_valid) && !ap_rst;
  assign rsp_hs   = (state_q == ST_HOLD) && rsp_ready[id_q];
  assign addr_sum = base_q
                  + {{(ADDR_W-PROD_W){1'b0}}, prod_use}
                  + {{(ADDR_W-COORD_W){1'b0}}, x_q};

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_ready = gnt ? 2'b10 : 2'b01;
          state_d   = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_done) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        rsp_valid = id_q ? 2'b10 : 2'b01;
        if (rsp_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
      pri_q   <= REQ_SRC;
      id_q    <= REQ_SRC;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q   <= gnt;
        x_q    <= req_x[gnt];
        y_q    <= req_y[gnt];
        base_q <= cfg_base[gnt];
        pri_q  <= ~gnt;
      end
      if ((state_q == ST_MUL) && mul_done) addr_q <= addr_sum;
      if (rsp_hs) cnt_q[id_q] <= cnt_q[id_q] + CNT_W'(1);
    end
  end

  assign rsp_addr   = addr_q;
  assign served_cnt = cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bitblt_mul_arb.sv
// Directed bench for bitblt_mul_arb; latency expectations follow BITBLT_MUL_PIPE_EN.
module tb_bitblt_mul_arb;

`ifdef BITBLT_MUL_PIPE_EN
  localparam int MUL_CYC = 2;
`else
  localparam int MUL_CYC = 1;
`endif

  logic             ap_clk = 1'b0;
  logic             ap_rst;
  logic [10:0]      cfg_stride;
  logic [1:0][31:0] cfg_base;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][10:0] req_x;
  logic [1:0][10:0] req_y;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_addr;
  logic [1:0][15:0] served_cnt;
  logic [1:0]       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  bitblt_mul_arb #(.ADDR_W(32), .CNT_W(16)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .cfg_stride (cfg_stride),
    .cfg_base   (cfg_base),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_addr   (rsp_addr),
    .served_cnt (served_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic        exp_id;
    logic [1:0]  exp_rdy;

    ap_rst      = 1'b1;
    req_valid   = 2'b11;
    rsp_ready   = 2'b00;
    cfg_stride  = 11'd640;
    cfg_base[0] = 32'h0000_1000;
    cfg_base[1] = 32'h0000_2000;
    req_x       = '0;
    req_y       = '0;
    #1;
    chk("rst_ready_low", req_ready, 2'b00);
    tick();
    tick();
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_addr", rsp_addr, 32'h0);
    chk("rst_cnt0", served_cnt[0], 16'd0);
    chk("rst_cnt1", served_cnt[1], 16'd0);
    chk("rst_ready_still_low", req_ready, 2'b00);

    // single request: 0x1000 + 3*640 + 5
    ap_rst    = 1'b0;
    req_valid = 2'b01;
    req_x[0]  = 11'd5;
    req_y[0]  = 11'd3;
    #1;
    chk("single_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    repeat (MUL_CYC) begin
      chk("single_no_early_valid", rsp_valid, 2'b00);
      tick();
    end
    chk("single_valid", rsp_valid, 2'b01);
    chk("single_addr", rsp_addr, 32'h0000_1785);
    chk("single_state_hold", dbg_state, 2'd2);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    chk("single_cnt0", served_cnt[0], 16'd1);
    chk("single_valid_drop", rsp_valid, 2'b00);
    chk("single_back_idle", dbg_state, 2'd0);

    // stall: pointer favours 1; rsp_ready[0] is not the active one
    req_x[0]  = 11'd1;
    req_y[0]  = 11'd1;
    req_x[1]  = 11'd10;
    req_y[1]  = 11'd2;
    req_valid = 2'b11;
    #1;
    chk("stall_grant1", req_ready, 2'b10);
    tick();
    repeat (MUL_CYC) tick();
    rsp_ready = 2'b01;
    repeat (5) begin
      chk("stall_valid", rsp_valid, 2'b10);
      chk("stall_addr", rsp_addr, 32'h0000_250A);
      chk("stall_no_grant", req_ready, 2'b00);
      tick();
    end
    rsp_ready = 2'b10;
    tick();
    chk("stall_cnt1", served_cnt[1], 16'd1);
    chk("stall_cnt0_unchanged", served_cnt[0], 16'd1);
    chk("stall_next_grant0", req_ready, 2'b01);

    // both valid, rsp_ready high: grants alternate 0,1,0,1
    rsp_ready = 2'b11;
    exp_id    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = exp_id ? 2'b10 : 2'b01;
      chk("alt_grant", req_ready, exp_rdy);
      exp_q.push_back(exp_id ? 32'h0000_250A : 32'h0000_1281);
      tick();
      repeat (MUL_CYC) tick();
      chk("alt_valid", rsp_valid, exp_rdy);
      chk("alt_addr", rsp_addr, exp_q.pop_front());
      tick();
      exp_id = ~exp_id;
    end
    req_valid = 2'b00;
    chk("alt_cnt0", served_cnt[0], 16'd5);
    chk("alt_cnt1", served_cnt[1], 16'd5);

    // maximum coordinates with wrapping base
    cfg_stride  = 11'd2047;
    cfg_base[0] = 32'hFFFF_FFFF;
    req_x[0]    = 11'd2047;
    req_y[0]    = 11'd2047;
    req_valid   = 2'b01;
    #1;
    chk("wrap_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    repeat (MUL_CYC) tick();
    chk("wrap_valid", rsp_valid, 2'b01);
    chk("wrap_addr", rsp_addr, 32'h003F_F7FF);
    tick();
    chk("wrap_cnt0", served_cnt[0], 16'd6);

    // reset during MUL with both requesters valid
    cfg_stride = 11'd640;
    req_valid  = 2'b11;
    #1;
    chk("mrst_grant1", req_ready, 2'b10);
    tick();
    chk("mrst_in_mul", dbg_state, 2'd1);
    ap_rst = 1'b1;
    #1;
    chk("mrst_ready_low", req_ready, 2'b00);
    tick();
    chk("mrst_state", dbg_state, 2'd0);
    chk("mrst_rsp_valid", rsp_valid, 2'b00);
    chk("mrst_addr", rsp_addr, 32'h0);
    chk("mrst_cnt0", served_cnt[0], 16'd0);
    chk("mrst_cnt1", served_cnt[1], 16'd0);
    ap_rst = 1'b0;
    #1;
    chk("mrst_release_grant0", req_ready, 2'b01);
    req_valid = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
